cpu_core: RTL and testbench
===========================

// Module: cpu_core
// PURPOSE
//   32-bit multi-cycle integer processor core for a 5-bit-opcode load/store ISA.
//   Fetches from an external synchronous instruction ROM, reads and writes an external
//   2-read/1-write register file, and accesses an external synchronous data RAM.
//   Sits at the top of the system between ROM, regfile and RAM. Holds only the PC,
//   the FSM state and the lw write-back latch.
// PARAMETERS
//   RESET_PC  0  word address loaded into the PC on reset
// PORTS
//   clock             in   1   system clock; all state changes on rising edge
//   reset             in   1   asynchronous, active-low reset
//   address_imem      out  32  instruction word address (= PC)
//   q_imem            in   32  instruction word; ROM registers it one rising edge after the address
//   ctrl_writeEnable  out  1   regfile write enable
//   ctrl_writeReg     out  5   regfile write index
//   ctrl_readRegA     out  5   regfile read port A index
//   ctrl_readRegB     out  5   regfile read port B index
//   data_writeReg     out  32  regfile write data
//   data_readRegA     in   32  combinational read data, port A
//   data_readRegB     in   32  combinational read data, port B
//   wren              out  1   data RAM write enable
//   address_dmem      out  32  data word address (RAM uses bits [11:0])
//   data              out  32  data RAM write data
//   q_dmem            in   32  data RAM read data, registered one rising edge after the address
// BEHAVIOUR
// * Reset (reset=0, asynchronous): PC=RESET_PC, state=FETCH.
//   - ctrl_writeEnable=0 and wren=0 immediately, even mid-instruction.
//   - All other outputs 0, except address_imem=PC.
// * Instruction fields: op[31:27] rd[26:22] rs[21:17] rt[16:12] shamt[11:7] aluop[6:2]
//   - imm[16:0] sign-extended to 32 bits; T[26:0] zero-extended.
// * FSM:
//   - FETCH: address_imem=PC; next state EXEC.
//   - EXEC: decode q_imem, compute, write back and update PC; lw goes to WB, all others go to FETCH.
//   - WB (lw only): ctrl_writeEnable=1, data_writeReg=q_dmem; next state FETCH.
//   - CPI: 2 for all instructions except lw (3). PC is updated at the end of EXEC; default PC+1.
// * Read-port mapping:
//   - ctrl_readRegA = rs (30 for bex).
//   - ctrl_readRegB = rt for R-type, rd otherwise.
// * R-type (op=00000), rd <= f(rs, rt) selected by aluop:
//   - 00000 add, 00001 sub, 00010 and, 00011 or
//   - 00100 sll by shamt, 00101 sra by shamt
//   - 00110 mul (low 32 bits of signed product), 00111 div (signed, truncating)
//   - Other aluop values: no operation.
// * I-type and jump-type, by opcode:
//   - 00101 addi: rd <= rs + imm
//   - 01000 lw: address_dmem = rs + imm in EXEC; the write to rd is done in WB
//   - 00111 sw: in EXEC, wren=1, address_dmem = rs + imm, data = $rd
//   - 00010 bne: if $rd != $rs, PC <= PC+1+imm
//   - 00110 blt: if $rd < $rs (signed), PC <= PC+1+imm
//   - 00001 j: PC <= T
//   - 00011 jal: $r31 <= PC+1, then PC <= T
//   - 00100 jr: PC <= $rd
//   - 10101 setx: $r30 <= T
//   - 10110 bex: if $r30 != 0, PC <= T
//   - Any other opcode: nop.
// * Exceptions replace the rd write with a write to r30 (rstatus):
//   - add overflow: 1; addi overflow: 2; sub overflow: 3
//   - mul overflow (product does not fit in 32 bits signed): 4
//   - div by zero: 5
// * Writes: ctrl_writeEnable is asserted only in EXEC/WB with a nonzero destination.
//   Writes to r0 are suppressed (enable stays 0).
// * Arithmetic wraps modulo 2^32. The PC is 32 bits and wraps.
// TESTING
// - Release reset; ROM[0] = addi $1,$0,5
//   -> cycle 2: rwe=1, rd=1, data 5; address_imem goes 0 -> 1.
// - $1=0x7FFFFFFF; add $2,$1,$1
//   -> write 1 into r30; r2 not written.
// - $1=5; sw $1,4($0) then lw $3,4($0)
//   -> sw EXEC: wren=1, addr 4, data 5; lw WB: 5 written to r3.
// - $1=5, $2=3
//   -> bne $1,$2,2 at PC 10: next PC 13.
//   -> blt $1,$2,2 at PC 10: next PC 11.
// - jal 100 at PC 7 -> r31=8, PC=100.
//   jr $31 -> PC=8.
//   setx 9 then bex 50 -> PC=50.
// - Assert reset during EXEC of sw -> wren=0 at once; PC=0 after reset release.

Source files
------------

// File: rtl/cpu_core.sv
// cpu_core: 32-bit multi-cycle integer core for a 5-bit-opcode load/store ISA.
// FETCH presents the PC to the synchronous instruction ROM, EXEC decodes the
// registered instruction, drives register-file and data-RAM accesses and
// advances the PC, and WB (lw only) writes the registered RAM data back.
// State held here: PC, FSM state and the lw destination index.

module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRA  = 5'b00101;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  lw_rd_q, lw_rd_d;

  // Signed-overflow detection for two's-complement add and subtract.
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  // Instruction fields, valid while in EXEC (ROM output is registered).
  logic [4:0]  op_s, rd_s, rs_s, rt_s, shamt_s, aluop_s;
  logic [31:0] imm_s, tgt_s;
  assign op_s    = q_imem[31:27];
  assign rd_s    = q_imem[26:22];
  assign rs_s    = q_imem[21:17];
  assign rt_s    = q_imem[16:12];
  assign shamt_s = q_imem[11:7];
  assign aluop_s = q_imem[6:2];
  assign imm_s   = {{15{q_imem[16]}}, q_imem[16:0]};
  assign tgt_s   = {5'd0, q_imem[26:0]};

  // Datapath results; selection happens in the control block below.
  logic [31:0] sum_s, diff_s, addi_s, sll_s, sra_s, pc_inc_s, br_tgt_s;
  logic [63:0] prod_s;
  logic        mul_ovf_s;
  logic [31:0] a_mag_s, b_mag_s, b_safe_s, q_mag_s, quot_s;

  assign sum_s    = data_readRegA + data_readRegB;
  assign diff_s   = data_readRegA - data_readRegB;
  assign addi_s   = data_readRegA + imm_s;
  assign sll_s    = data_readRegA << shamt_s;
  assign sra_s    = $signed(data_readRegA) >>> shamt_s;
  assign pc_inc_s = pc_q + 32'd1;
  assign br_tgt_s = pc_inc_s + imm_s;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s    = {{32{data_readRegA[31]}}, data_readRegA} * {{32{data_readRegB[31]}}, data_readRegB};
  assign mul_ovf_s = (prod_s[63:32] != {32{prod_s[31]}});

  // Sign-magnitude division truncates toward zero; a zero divisor is replaced
  // so the divider never sees it (that case raises an exception instead).
  assign a_mag_s  = data_readRegA[31] ? (32'd0 - data_readRegA) : data_readRegA;
  assign b_mag_s  = data_readRegB[31] ? (32'd0 - data_readRegB) : data_readRegB;
  assign b_safe_s = (data_readRegB == 32'd0) ? 32'd1 : b_mag_s;
  assign q_mag_s  = a_mag_s / b_safe_s;
  assign quot_s   = (data_readRegA[31] ^ data_readRegB[31]) ? (32'd0 - q_mag_s) : q_mag_s;

  // Pending register-file write chosen by the decoder, gated for r0 at the port.
  logic        wr_en_s;
  logic [4:0]  wr_idx_s;
  logic [31:0] wr_data_s;

  // State, PC and lw-destination registers; reset forces FETCH at RESET_PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      lw_rd_q <= 5'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lw_rd_q <= lw_rd_d;
    end
  end

  // Next-state, PC update and all memory/regfile control outputs.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    lw_rd_d          = lw_rd_q;
    address_imem     = pc_q;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    wren             = 1'b0;
    address_dmem     = 32'd0;
    data             = 32'd0;
    wr_en_s          = 1'b0;
    wr_idx_s         = 5'd0;
    wr_data_s        = 32'd0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;

    case (state_q)
      S_FETCH: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d       = S_FETCH;
        pc_d          = pc_inc_s;
        ctrl_readRegA = (op_s == OP_BEX) ? REG_STATUS : rs_s;
        ctrl_readRegB = (op_s == OP_RTYPE) ? rt_s : rd_s;
        case (op_s)
          OP_RTYPE: begin
            wr_en_s  = 1'b1;
            wr_idx_s = rd_s;
            case (aluop_s)
              ALU_ADD: begin
                if (add_ovf(data_readRegA, data_readRegB, sum_s)) begin
                  wr_idx_s  = REG_STATUS;
                  wr_data_s = 32'd1;
                end else begin
                  wr_data_s = sum_s;
                end
              end
              ALU_SUB: begin
                if (sub_ovf(data_readRegA, data_readRegB, diff_s)) begin
                  wr_idx_s  = REG_STATUS;
                  wr_data_s = 32'd3;
                end else begin
                  wr_data_s = diff_s;
                end
              end
              ALU_AND: wr_data_s = data_readRegA & data_readRegB;
              ALU_OR:  wr_data_s = data_readRegA | data_readRegB;
              ALU_SLL: wr_data_s = sll_s;
              ALU_SRA: wr_data_s = sra_s;
              ALU_MUL: begin
                if (mul_ovf_s) begin
                  wr_idx_s  = REG_STATUS;
                  wr_data_s = 32'd4;
                end else begin
                  wr_data_s = prod_s[31:0];
                end
              end
              ALU_DIV: begin
                if (data_readRegB == 32'd0) begin
                  wr_idx_s  = REG_STATUS;
                  wr_data_s = 32'd5;
                end else begin
                  wr_data_s = quot_s;
                end
              end
              default: wr_en_s = 1'b0;
            endcase
          end
          OP_ADDI: begin
            wr_en_s = 1'b1;
            if (add_ovf(data_readRegA, imm_s, addi_s)) begin
              wr_idx_s  = REG_STATUS;
              wr_data_s = 32'd2;
            end else begin
              wr_idx_s  = rd_s;
              wr_data_s = addi_s;
            end
          end
          OP_LW: begin
            address_dmem = addi_s;
            lw_rd_d      = rd_s;
            state_d      = S_WB;
          end
          OP_SW: begin
            wren         = 1'b1;
            address_dmem = addi_s;
            data         = data_readRegB;
          end
          OP_BNE: begin
            if (data_readRegB != data_readRegA) begin
              pc_d = br_tgt_s;
            end else begin
              pc_d = pc_inc_s;
            end
          end
          OP_BLT: begin
            if ($signed(data_readRegB) < $signed(data_readRegA)) begin
              pc_d = br_tgt_s;
            end else begin
              pc_d = pc_inc_s;
            end
          end
          OP_J: pc_d = tgt_s;
          OP_JAL: begin
            wr_en_s   = 1'b1;
            wr_idx_s  = REG_LINK;
            wr_data_s = pc_inc_s;
            pc_d      = tgt_s;
          end
          OP_JR: pc_d = data_readRegB;
          OP_SETX: begin
            wr_en_s   = 1'b1;
            wr_idx_s  = REG_STATUS;
            wr_data_s = tgt_s;
          end
          OP_BEX: begin
            if (data_readRegA != 32'd0) begin
              pc_d = tgt_s;
            end else begin
              pc_d = pc_inc_s;
            end
          end
          default: pc_d = pc_inc_s;
        endcase
      end

      S_WB: begin
        state_d   = S_FETCH;
        wr_en_s   = 1'b1;
        wr_idx_s  = lw_rd_q;
        wr_data_s = q_dmem;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (wr_en_s && (wr_idx_s != 5'd0)) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = wr_idx_s;
      data_writeReg    = wr_data_s;
    end else begin
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = 5'd0;
      data_writeReg    = 32'd0;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: provides ROM, register file and data RAM,
// and checks every instruction against an ISA-level interpreter.

module tb_cpu_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  always #5 clock = ~clock;

  cpu_core #(.RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
  );

  // System environment: ROM, regfile and RAM seen by the DUT
  logic [31:0] rom      [256];
  logic [31:0] rf       [32];
  logic [31:0] rf_init  [32];
  logic [31:0] ram      [4096];
  logic [31:0] ram_init [4096];

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

  always @(posedge clock) begin
    if (!reset) begin
      rf  <= rf_init;
      ram <= ram_init;
    end else begin
      if (wren) ram[address_dmem[11:0]] <= data;
      if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
    end
    q_imem <= rom[address_imem[7:0]];
    q_dmem <= ram[address_dmem[11:0]];
  end

  // Architectural reference model
  logic [31:0] mr   [32];
  logic [31:0] mmem [4096];
  logic [31:0] mpc;
  logic        m_we, m_wren, m_lw;
  logic [4:0]  m_wreg, m_ra, m_rb, m_lw_rd;
  logic [31:0] m_wdata, m_daddr, m_ddata, m_lw_data, m_npc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (pc=%0d)", name, act, exp, mpc);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [4:0] alu);
    return {5'd0, rd, rs, rt, sh, alu, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  op;
    int k;
    k = $urandom_range(0, 15);
    case (k)
      0, 1, 2, 3, 4: op = 5'd0;
      5:  op = 5'd5;
      6:  op = 5'd8;
      7:  op = 5'd7;
      8:  op = 5'd2;
      9:  op = 5'd6;
      10: op = 5'd1;
      11: op = 5'd3;
      12: op = 5'd4;
      13: op = 5'd21;
      14: op = 5'd22;
      default: op = 5'($urandom_range(9, 20));
    endcase
    w = $urandom;
    w[31:27] = op;
    if (op == 5'd0) w[6:2] = 5'($urandom_range(0, 9));
    return w;
  endfunction

  // Interpret one instruction word at mpc; results go to the m_* variables.
  task automatic model_step(input logic [31:0] w);
    logic [4:0]  op, rd, rs, rt, sh, alu, widx;
    logic [31:0] a, brd, brt, imm, t, wval;
    logic        wdo, valid;
    longint      sa, sb, r, exc;
    longint      maxi, mini;
    maxi = 64'sd2147483647;
    mini = -64'sd2147483648;
    op = w[31:27]; rd = w[26:22]; rs = w[21:17]; rt = w[16:12]; sh = w[11:7]; alu = w[6:2];
    imm = 32'(longint'($signed(w[16:0])));
    t   = 32'(w[26:0]);
    m_ra = (op == 5'd22) ? 5'd30 : rs;
    m_rb = (op == 5'd0) ? rt : rd;
    a = mr[m_ra]; brd = mr[rd]; brt = mr[rt];
    sa = longint'($signed(a));
    sb = longint'($signed(brt));
    m_we = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
    m_wren = 1'b0; m_daddr = 32'd0; m_ddata = 32'd0;
    m_lw = 1'b0; m_lw_rd = 5'd0; m_lw_data = 32'd0;
    m_npc = mpc + 32'd1;
    wdo = 1'b0; widx = 5'd0; wval = 32'd0; r = 0; exc = 0; valid = 1'b1;
    case (op)
      5'd0: begin
        case (alu)
          5'd0: begin r = sa + sb; if (r > maxi || r < mini) exc = 1; end
          5'd1: begin r = sa - sb; if (r > maxi || r < mini) exc = 3; end
          5'd2: r = longint'(a & brt);
          5'd3: r = longint'(a | brt);
          5'd4: r = longint'(a << sh);
          5'd5: r = sa >>> sh;
          5'd6: begin r = sa * sb; if (r > maxi || r < mini) exc = 4; end
          5'd7: begin if (sb == 0) exc = 5; else r = sa / sb; end
          default: valid = 1'b0;
        endcase
        if (valid) begin
          wdo = 1'b1;
          widx = (exc != 0) ? 5'd30 : rd;
          wval = (exc != 0) ? 32'(exc) : r[31:0];
        end
      end
      5'd5: begin
        r = sa + longint'($signed(imm));
        wdo = 1'b1;
        if (r > maxi || r < mini) begin widx = 5'd30; wval = 32'd2; end
        else begin widx = rd; wval = r[31:0]; end
      end
      5'd8: begin
        m_lw = 1'b1; m_daddr = a + imm; m_lw_rd = rd; m_lw_data = mmem[m_daddr[11:0]];
      end
      5'd7: begin m_wren = 1'b1; m_daddr = a + imm; m_ddata = brd; end
      5'd2: if (brd != a) m_npc = mpc + 32'd1 + imm;
      5'd6: if ($signed(brd) < $signed(a)) m_npc = mpc + 32'd1 + imm;
      5'd1: m_npc = t;
      5'd3: begin wdo = 1'b1; widx = 5'd31; wval = mpc + 32'd1; m_npc = t; end
      5'd4: m_npc = brd;
      5'd21: begin wdo = 1'b1; widx = 5'd30; wval = t; end
      5'd22: if (a != 32'd0) m_npc = t;
      default: ;
    endcase
    m_we = wdo && (widx != 5'd0);
    m_wreg = widx;
    m_wdata = wval;
  endtask

  // Run one instruction on the DUT, starting and ending in its FETCH cycle.
  task automatic run_instr();
    model_step(rom[mpc[7:0]]);
    chk("fetch_pc", address_imem, mpc);
    chk("fetch_we", 32'(ctrl_writeEnable), 32'd0);
    chk("fetch_wren", 32'(wren), 32'd0);
    @(negedge clock); #1;
    chk("exec_pc", address_imem, mpc);
    chk("exec_ra", 32'(ctrl_readRegA), 32'(m_ra));
    chk("exec_rb", 32'(ctrl_readRegB), 32'(m_rb));
    chk("exec_we", 32'(ctrl_writeEnable), 32'(m_we));
    if (m_we) begin
      chk("exec_wreg", 32'(ctrl_writeReg), 32'(m_wreg));
      chk("exec_wdata", data_writeReg, m_wdata);
    end
    chk("exec_wren", 32'(wren), 32'(m_wren));
    if (m_wren || m_lw) chk("exec_daddr", address_dmem, m_daddr);
    if (m_wren) chk("exec_ddata", data, m_ddata);
    if (m_lw) begin
      @(negedge clock); #1;
      chk("wb_we", 32'(ctrl_writeEnable), 32'(m_lw_rd != 5'd0));
      if (m_lw_rd != 5'd0) begin
        chk("wb_wreg", 32'(ctrl_writeReg), 32'(m_lw_rd));
        chk("wb_wdata", data_writeReg, m_lw_data);
      end
      chk("wb_wren", 32'(wren), 32'd0);
    end
    @(negedge clock); #1;
    if (m_we) mr[m_wreg] = m_wdata;
    if (m_wren) mmem[m_daddr[11:0]] = m_ddata;
    if (m_lw && m_lw_rd != 5'd0) mr[m_lw_rd] = m_lw_data;
    mr[0] = 32'd0;
    mpc = m_npc;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
    for (int i = 0; i < 32; i++)
      rf_init[i] = (i % 2 == 1) ? $urandom : (32'($urandom_range(0, 40)) - 32'd20);
    rf_init[0]  = 32'd0;
    rf_init[12] = 32'h7FFF_FFFF;
    rf_init[17] = 32'h8000_0000;
    for (int i = 0; i < 4096; i++) ram_init[i] = $urandom;

    rom[0]   = enc_i(5'd5, 5'd1, 5'd0, 17'd5);     // addi $1,$0,5
    rom[1]   = enc_i(5'd7, 5'd1, 5'd0, 17'd4);     // sw $1,4($0)
    rom[2]   = enc_i(5'd8, 5'd3, 5'd0, 17'd4);     // lw $3,4($0)
    rom[3]   = enc_i(5'd5, 5'd2, 5'd0, 17'd3);     // addi $2,$0,3
    rom[4]   = enc_i(5'd2, 5'd1, 5'd2, 17'd2);     // bne $1,$2,2
    rom[7]   = enc_j(5'd3, 27'd100);               // jal 100
    rom[100] = enc_i(5'd4, 5'd31, 5'd0, 17'd0);    // jr $31
    rom[8]   = enc_i(5'd6, 5'd1, 5'd2, 17'd2);     // blt $1,$2,2
    rom[9]   = enc_j(5'd21, 27'd9);                // setx 9
    rom[10]  = enc_j(5'd22, 27'd50);               // bex 50
    rom[50]  = enc_r(5'd13, 5'd12, 5'd12, 5'd0, 5'd0); // add overflow
    rom[51]  = enc_r(5'd14, 5'd12, 5'd0, 5'd0, 5'd7);  // div by zero
    rom[52]  = enc_r(5'd15, 5'd12, 5'd12, 5'd0, 5'd6); // mul overflow
    rom[53]  = enc_r(5'd16, 5'd0, 5'd17, 5'd0, 5'd1);  // sub overflow

    mr = rf_init; mmem = ram_init; mpc = 32'd0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_imem", address_imem, 32'd0);
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_daddr", address_dmem, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_wdata", data_writeReg, 32'd0);
    chk("rst_rra", 32'(ctrl_readRegA), 32'd0);
    reset = 1'b1;

    // Directed program with hand-computed pins on the model
    run_instr(); chk("pin_addi_we", 32'(m_we), 32'd1); chk("pin_addi_reg", 32'(m_wreg), 32'd1);
                 chk("pin_addi_data", m_wdata, 32'd5); chk("pin_addi_npc", m_npc, 32'd1);
    run_instr(); chk("pin_sw_wren", 32'(m_wren), 32'd1); chk("pin_sw_addr", m_daddr, 32'd4);
                 chk("pin_sw_data", m_ddata, 32'd5);
    run_instr(); chk("pin_lw_rd", 32'(m_lw_rd), 32'd3); chk("pin_lw_data", m_lw_data, 32'd5);
    run_instr(); chk("pin_addi2_data", m_wdata, 32'd3);
    run_instr(); chk("pin_bne_npc", m_npc, 32'd7);
    run_instr(); chk("pin_jal_reg", 32'(m_wreg), 32'd31); chk("pin_jal_data", m_wdata, 32'd8);
                 chk("pin_jal_npc", m_npc, 32'd100);
    run_instr(); chk("pin_jr_npc", m_npc, 32'd8);
    run_instr(); chk("pin_blt_npc", m_npc, 32'd9);
    run_instr(); chk("pin_setx_reg", 32'(m_wreg), 32'd30); chk("pin_setx_data", m_wdata, 32'd9);
    run_instr(); chk("pin_bex_npc", m_npc, 32'd50);
    run_instr(); chk("pin_addovf_reg", 32'(m_wreg), 32'd30); chk("pin_addovf_data", m_wdata, 32'd1);
    run_instr(); chk("pin_div0_data", m_wdata, 32'd5);
    run_instr(); chk("pin_mulovf_data", m_wdata, 32'd4);
    run_instr(); chk("pin_subovf_data", m_wdata, 32'd3);

    // Random program continuation
    repeat (400) run_instr();

    // Reset asserted in the middle of an sw EXEC cycle
    reset = 1'b0;
    rom[0]   = enc_j(5'd1, 27'd200);               // j 200
    rom[200] = enc_i(5'd7, 5'd1, 5'd0, 17'd4);     // sw $1,4($0)
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    mr = rf_init; mmem = ram_init; mpc = 32'd0;
    reset = 1'b1;
    run_instr(); chk("pin_j_npc", m_npc, 32'd200);
    chk("sw_fetch_pc", address_imem, 32'd200);
    @(negedge clock); #1;
    chk("sw_exec_wren", 32'(wren), 32'd1);
    chk("sw_exec_addr", address_dmem, 32'd4);
    chk("sw_exec_data", data, rf_init[1]);
    reset = 1'b0;
    #1;
    chk("midrst_wren", 32'(wren), 32'd0);
    chk("midrst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("midrst_imem", address_imem, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    mr = rf_init; mmem = ram_init; mpc = 32'd0;
    reset = 1'b1;
    #1;
    chk("post_rst_imem", address_imem, 32'd0);
    run_instr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
